quad_step_decoder: RTL and testbench

QUAD_STEP_DECODER -- requirements
Module: quad_step_decoder

---
 rtl/quad_step_decoder.sv | 237 +++++++++++++++++++++++
 tb/tb_quad_step_decoder.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/quad_step_decoder.sv
// Quadrature encoder front end: synchronize, debounce and decode A/B into step/direction pulses.
// Latency: DEBOUNCE_CYCLES+3 rising edges from a raw level change to the registered step/err pulse.
// Backpressure: none; the encoder cannot be stalled, so every decoded step pulses exactly once.
//
// Ports:
//   clk      - sole clock, all state updates on the rising edge
//   reset    - synchronous, active-high
//   enc_a    - raw encoder channel A (asynchronous to clk)
//   enc_b    - raw encoder channel B (asynchronous to clk)
//   step     - one-cycle pulse per decoded step (counter enable)
//   up_down  - direction of the latest step, 1 = up, 0 = down (counter direction)
//   err      - one-cycle pulse on an illegal quadrature transition
//   armed    - high once the inputs have settled after reset and decoding is active
module quad_step_decoder #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter bit          X4_MODE         = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic enc_a,
    input  logic enc_b,
    output logic step,
    output logic up_down,
    output logic err,
    output logic armed
);

    // Counter widths: debounce counter never exceeds DEBOUNCE_CYCLES-1 (<= 254),
    // the settle counter never exceeds DEBOUNCE_CYCLES+1 (<= 256).
    localparam logic [8:0] DB_LIMIT    = 9'(DEBOUNCE_CYCLES);
    localparam logic [8:0] SETTLE_LAST = 9'(DEBOUNCE_CYCLES + 1);

    typedef enum logic [1:0] {
        TR_NONE,
        TR_UP,
        TR_DOWN,
        TR_ILLEGAL
    } trans_t;

    // ------------------------------------------------------------------
    // Two-flop synchronizers; bit [1] is the only stage the rest of the
    // design is allowed to look at.
    // ------------------------------------------------------------------
    logic [1:0] sync_a;
    logic [1:0] sync_b;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= {sync_a[0], enc_a};
            sync_b <= {sync_b[0], enc_b};
        end
    end

    // ------------------------------------------------------------------
    // Debounce filters. A counter runs while the synchronized level
    // disagrees with the filtered level and is cleared whenever they
    // agree, so only an uninterrupted disagreement of DEBOUNCE_CYCLES
    // cycles flips the filtered value.
    // ------------------------------------------------------------------
    logic [7:0] cnt_a, cnt_b;
    logic [7:0] cnt_a_nxt, cnt_b_nxt;
    logic       filt_a, filt_b;
    logic       filt_a_nxt, filt_b_nxt;
    logic [8:0] cnt_a_inc, cnt_b_inc;

    assign cnt_a_inc = {1'b0, cnt_a} + 9'd1;
    assign cnt_b_inc = {1'b0, cnt_b} + 9'd1;

    always_comb begin
        cnt_a_nxt  = '0;
        filt_a_nxt = filt_a;
        if (sync_a[1] != filt_a) begin
            if (cnt_a_inc == DB_LIMIT) begin
                // Counter would reach the limit: accept the new level and
                // leave the counter cleared for the next change.
                filt_a_nxt = ~filt_a;
            end else begin
                cnt_a_nxt = cnt_a_inc[7:0];
            end
        end
    end

    always_comb begin
        cnt_b_nxt  = '0;
        filt_b_nxt = filt_b;
        if (sync_b[1] != filt_b) begin
            if (cnt_b_inc == DB_LIMIT) begin
                filt_b_nxt = ~filt_b;
            end else begin
                cnt_b_nxt = cnt_b_inc[7:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_a  <= '0;
            cnt_b  <= '0;
            filt_a <= 1'b0;
            filt_b <= 1'b0;
        end else begin
            cnt_a  <= cnt_a_nxt;
            cnt_b  <= cnt_b_nxt;
            filt_a <= filt_a_nxt;
            filt_b <= filt_b_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Arming: wait until both channels have agreed with their filtered
    // values for DEBOUNCE_CYCLES+2 consecutive cycles, so whatever level
    // the encoder sits at after reset is absorbed silently.
    // ------------------------------------------------------------------
    logic       settled_now;
    logic [8:0] settle_cnt;

    assign settled_now = (sync_a[1] == filt_a) && (sync_b[1] == filt_b);

    always_ff @(posedge clk) begin
        if (reset) begin
            settle_cnt <= '0;
            armed      <= 1'b0;
        end else if (!armed) begin
            if (settled_now) begin
                if (settle_cnt == SETTLE_LAST) begin
                    armed <= 1'b1;
                end else begin
                    settle_cnt <= settle_cnt + 9'd1;
                end
            end else begin
                settle_cnt <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Transition classification. The previous quadrature state is kept
    // one cycle behind the filtered state, so a filtered update is seen
    // here the cycle after it happens and the result lands in the output
    // register on the following edge.
    // ------------------------------------------------------------------
    logic [1:0] quad;
    logic [1:0] quad_prev;
    trans_t     trans;

    assign quad = {filt_a, filt_b};

    always_ff @(posedge clk) begin
        if (reset) begin
            quad_prev <= 2'b00;
        end else begin
            quad_prev <= quad;
        end
    end

    // Up sequence is 00 -> 01 -> 11 -> 10 -> 00; both bits changing at
    // once cannot be attributed to a direction.
    always_comb begin
        trans = TR_NONE;
        case ({quad_prev, quad})
            4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: trans = TR_UP;
            4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: trans = TR_DOWN;
            4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: trans = TR_ILLEGAL;
            default:                                 trans = TR_NONE;
        endcase
    end

    // ------------------------------------------------------------------
    // Step generation. In x1 mode the accumulator counts edges within a
    // detent; it is cleared the moment it would reach +/-4, so the stored
    // value always stays within -3..+3.
    // ------------------------------------------------------------------
    logic signed [3:0] acc;
    logic signed [3:0] acc_nxt;
    logic              step_nxt;
    logic              err_nxt;
    logic              up_down_nxt;

    always_comb begin
        step_nxt    = 1'b0;
        err_nxt     = 1'b0;
        up_down_nxt = up_down;
        acc_nxt     = acc;
        if (armed) begin
            case (trans)
                TR_UP: begin
                    if (X4_MODE) begin
                        step_nxt    = 1'b1;
                        up_down_nxt = 1'b1;
                    end else if (acc == 4'sd3) begin
                        step_nxt    = 1'b1;
                        up_down_nxt = 1'b1;
                        acc_nxt     = 4'sd0;
                    end else begin
                        acc_nxt = acc + 4'sd1;
                    end
                end
                TR_DOWN: begin
                    if (X4_MODE) begin
                        step_nxt    = 1'b1;
                        up_down_nxt = 1'b0;
                    end else if (acc == -4'sd3) begin
                        step_nxt    = 1'b1;
                        up_down_nxt = 1'b0;
                        acc_nxt     = 4'sd0;
                    end else begin
                        acc_nxt = acc - 4'sd1;
                    end
                end
                TR_ILLEGAL: begin
                    err_nxt = 1'b1;
                    acc_nxt = 4'sd0;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc     <= 4'sd0;
            step    <= 1'b0;
            err     <= 1'b0;
            up_down <= 1'b1;
        end else begin
            acc     <= acc_nxt;
            step    <= step_nxt;
            err     <= err_nxt;
            up_down <= up_down_nxt;
        end
    end

endmodule

// File: tb/tb_quad_step_decoder.sv
`timescale 1ns/1ps
module tb_quad_step_decoder;

    localparam int D = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic enc_a = 1'b0;
    logic enc_b = 1'b0;
    logic step4, ud4, err4, armed4;
    logic step1, ud1, err1, armed1;

    always #5 clk = ~clk;

    quad_step_decoder #(.DEBOUNCE_CYCLES(D), .X4_MODE(1'b1)) dut4 (
        .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b),
        .step(step4), .up_down(ud4), .err(err4), .armed(armed4)
    );

    quad_step_decoder #(.DEBOUNCE_CYCLES(D), .X4_MODE(1'b0)) dut1 (
        .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b),
        .step(step1), .up_down(ud1), .err(err1), .armed(armed1)
    );

    int checks = 0;
    int passed = 0;
    int cyc = 0;
    int n_step4 = 0, n_err4 = 0, n_step1 = 0, n_err1 = 0;
    bit started = 1'b0;

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // ------------------------------------------------------------------
    // Reference model. Raw samples are kept as a history (newest first);
    // the synchronized value seen at an edge is the raw sample from two
    // edges earlier. A filtered channel flips when the last D synchronized
    // samples all disagree with it. Positions are Gray-decoded to 0..3 and
    // direction is the modular difference between successive positions.
    // ------------------------------------------------------------------
    bit ha[$], hb[$], heq[$];
    bit mfa, mfb, mfa_o, mfb_o, m_armed;
    int acc;
    bit e_step4, e_ud4, e_step1, e_ud1, e_err;

    function automatic int gidx(input bit a, input bit b);
        return (a ? 2 : 0) + ((a ^ b) ? 1 : 0);
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            ha.delete(); hb.delete(); heq.delete();
            for (int i = 0; i < D + 4; i++) begin
                ha.push_front(1'b0); hb.push_front(1'b0); heq.push_front(1'b0);
            end
            mfa = 0; mfb = 0; mfa_o = 0; mfb_o = 0; m_armed = 0; acc = 0;
            e_step4 = 0; e_step1 = 0; e_err = 0; e_ud4 = 1; e_ud1 = 1;
            started = 1'b1;
        end else begin
            int d;
            bit all_a, all_b, ok, eq_now;
            e_step4 = 0; e_step1 = 0; e_err = 0;
            d = (gidx(mfa, mfb) - gidx(mfa_o, mfb_o)) & 3;
            if (m_armed) begin
                if (d == 2) begin
                    e_err = 1; acc = 0;
                end else if (d == 1 || d == 3) begin
                    e_step4 = 1; e_ud4 = (d == 1);
                    acc += (d == 1) ? 1 : -1;
                    if (acc == 4 || acc == -4) begin
                        e_step1 = 1; e_ud1 = (acc == 4); acc = 0;
                    end
                end
            end
            eq_now = (ha[1] == mfa) && (hb[1] == mfb);
            all_a = 1; all_b = 1;
            for (int j = 0; j < D; j++) begin
                if (ha[1 + j] == mfa) all_a = 0;
                if (hb[1 + j] == mfb) all_b = 0;
            end
            heq.push_front(eq_now);
            ok = 1;
            for (int j = 0; j < D + 2; j++) if (!heq[j]) ok = 0;
            if (ok) m_armed = 1;
            mfa_o = mfa; mfb_o = mfb;
            if (all_a) mfa = !mfa;
            if (all_b) mfb = !mfb;
            ha.push_front(enc_a); hb.push_front(enc_b);
            while (ha.size() > D + 4) ha.pop_back();
            while (hb.size() > D + 4) hb.pop_back();
            while (heq.size() > D + 4) heq.pop_back();
        end
    end

    // Single compare process, every cycle, away from the active edge.
    always @(negedge clk) begin
        if (started) begin
            chk("step_x4", step4, e_step4);
            chk("up_down_x4", ud4, e_ud4);
            chk("err_x4", err4, e_err);
            chk("armed_x4", armed4, m_armed);
            chk("step_x1", step1, e_step1);
            chk("up_down_x1", ud1, e_ud1);
            chk("err_x1", err1, e_err);
            chk("armed_x1", armed1, m_armed);
            if (step4) n_step4++;
            if (err4)  n_err4++;
            if (step1) n_step1++;
            if (err1)  n_err1++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive a new raw level and hold it; report edges from the first
    // sampling edge to the step pulse (-1 if none within the hold).
    task automatic move(input bit a, input bit b, input int hold, output int lat);
        int first;
        lat = -1;
        enc_a = a; enc_b = b;
        first = cyc + 1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (step4 && lat < 0) lat = cyc - first + 1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int lat, s4, s1, e4, e1, rel;
        int cur, nxt, len;
        bit na, nb;

        reset = 1; enc_a = 0; enc_b = 0;
        tick(3);
        reset = 0;
        rel = cyc;
        tick(D + 1);
        chk_int("armed_not_yet", int'(armed4), 0);
        tick(1);
        chk_int("armed_at_d_plus_2", int'(armed4), 1);
        chk_int("armed_cycle", cyc - rel, D + 2);
        tick(4);

        // Up sequence, x4: four steps, each D+3 edges after its raw change.
        s4 = n_step4; s1 = n_step1;
        move(0, 1, 10, lat); chk_int("lat_up1", lat, 7);
        move(1, 1, 10, lat); chk_int("lat_up2", lat, 7);
        move(1, 0, 10, lat); chk_int("lat_up3", lat, 7);
        move(0, 0, 10, lat); chk_int("lat_up4", lat, 7);
        chk_int("up_steps_x4", n_step4 - s4, 4);
        chk_int("up_dir_x4", int'(ud4), 1);
        chk_int("up_steps_x1", n_step1 - s1, 1);
        chk_int("up_dir_x1", int'(ud1), 1);

        // Reverse sequence.
        s4 = n_step4; s1 = n_step1;
        move(1, 0, 10, lat); chk_int("lat_dn1", lat, 7);
        move(1, 1, 10, lat);
        move(0, 1, 10, lat);
        move(0, 0, 10, lat);
        tick(10);
        chk_int("dn_steps_x4", n_step4 - s4, 4);
        chk_int("dn_dir_hold_x4", int'(ud4), 0);
        chk_int("dn_steps_x1", n_step1 - s1, 1);
        chk_int("dn_dir_x1", int'(ud1), 0);

        // Short glitch on A: never reaches the filter.
        s4 = n_step4; e4 = n_err4;
        enc_a = 1; tick(D - 1); enc_a = 0; tick(15);
        chk_int("glitch_steps", n_step4 - s4, 0);
        chk_int("glitch_errs", n_err4 - e4, 0);

        // Both channels together: one error, no step.
        s4 = n_step4; e4 = n_err4; s1 = n_step1; e1 = n_err1;
        enc_a = 1; enc_b = 1; tick(15);
        chk_int("dbl_errs_x4", n_err4 - e4, 1);
        chk_int("dbl_steps_x4", n_step4 - s4, 0);
        chk_int("dbl_errs_x1", n_err1 - e1, 1);
        chk_int("dbl_steps_x1", n_step1 - s1, 0);
        enc_a = 0; enc_b = 0; tick(15);

        // x1: up,up,down,up,up,up -> one up step on the 6th edge.
        s1 = n_step1;
        move(0, 1, 10, lat); move(1, 1, 10, lat); move(0, 1, 10, lat);
        move(1, 1, 10, lat); move(1, 0, 10, lat);
        chk_int("x1_no_step_before_6th", n_step1 - s1, 0);
        move(0, 0, 10, lat);
        chk_int("x1_step_on_6th", n_step1 - s1, 1);
        chk_int("x1_step_dir", int'(ud1), 1);
        move(0, 1, 10, lat); move(1, 1, 10, lat); move(1, 0, 10, lat);
        chk_int("x1_acc_cleared", n_step1 - s1, 1);
        move(0, 0, 10, lat);
        chk_int("x1_next_detent", n_step1 - s1, 2);

        // Release reset with both inputs high: arm silently.
        s4 = n_step4; e4 = n_err4;
        reset = 1; enc_a = 1; enc_b = 1; tick(3);
        reset = 0; tick(25);
        chk_int("arm_high_inputs", int'(armed4), 1);
        chk_int("arm_high_steps", n_step4 - s4, 0);
        chk_int("arm_high_errs", n_err4 - e4, 0);

        // Reset two edges after a raw change discards it.
        s4 = n_step4; e4 = n_err4;
        enc_a = 0; tick(2);
        reset = 1; tick(2); reset = 0; tick(20);
        chk_int("rst_mid_steps", n_step4 - s4, 0);
        chk_int("rst_mid_errs", n_err4 - e4, 0);

        // Randomized phase: walks, glitches, double toggles, resets.
        for (int it = 0; it < 400; it++) begin
            int r;
            r = $urandom_range(0, 99);
            len = $urandom_range(1, 12);
            if (r < 65) begin
                cur = gidx(enc_a, enc_b);
                nxt = ($urandom_range(0, 1) == 1) ? ((cur + 1) & 3) : ((cur + 3) & 3);
                na = (nxt >= 2);
                nb = na ^ nxt[0];
                enc_a = na; enc_b = nb;
                tick(len);
            end else if (r < 78) begin
                if ($urandom_range(0, 1) == 1) begin
                    enc_a = !enc_a; tick($urandom_range(1, D - 1)); enc_a = !enc_a;
                end else begin
                    enc_b = !enc_b; tick($urandom_range(1, D - 1)); enc_b = !enc_b;
                end
                tick(len);
            end else if (r < 88) begin
                enc_a = !enc_a; enc_b = !enc_b;
                tick(len);
            end else if (r < 91) begin
                reset = 1; tick($urandom_range(1, 3)); reset = 0;
                tick(len);
            end else begin
                tick(len);
            end
        end
        tick(D + 10);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
